// File: rtl/muon_capture_sequencer.sv
// muon_capture_sequencer: acquisition controller for the muon-decay datapath.
// Runs a circular sample-buffer write pointer while armed and accepts a
// double-pulse trigger on its rising edge. After the trigger it captures a
// programmable number of post-trigger samples, then freezes the buffer for
// CPU readout. After readout it waits out a programmable dead time and
// re-arms.
// Optional macro MISSED_TRIG_EN adds missed_count, which counts trigger edges
// lost while busy (POST, READY or HOLDOFF).
module muon_capture_sequencer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_en,
  input  logic              trig_in,
  input  logic [15:0]       post_samples,
  input  logic [15:0]       holdoff,
  input  logic              rd_ack,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              data_ready,
  output logic [CNT_W-1:0]  event_count,
  output logic [CNT_W-1:0]  event_time,
  output logic [2:0]        state
`ifdef MISSED_TRIG_EN
  ,
  output logic [CNT_W-1:0]  missed_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_READY   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_buf_we;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_data_ready;
  logic [CNT_W-1:0]  r_event_count;
  logic [CNT_W-1:0]  r_event_time;
  logic [CNT_W-1:0]  r_timestamp;
  logic [15:0]       r_post_cnt;
  logic [15:0]       r_hold_cnt;
  logic              r_trig_d;
  logic              w_trig_rise;

  assign w_trig_rise = trig_in & ~r_trig_d;

  assign state       = r_state;
  assign buf_we      = r_buf_we;
  assign buf_addr    = r_buf_addr;
  assign trig_addr   = r_trig_addr;
  assign data_ready  = r_data_ready;
  assign event_count = r_event_count;
  assign event_time  = r_event_time;

  // Free-running timestamp and trigger delay register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timestamp <= '0;
      r_trig_d    <= 1'b0;
    end else begin
      r_timestamp <= r_timestamp + CNT_W'(1);
      r_trig_d    <= trig_in;
    end
  end

  // Acquisition FSM with registered outputs and write-pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_buf_we      <= 1'b0;
      r_buf_addr    <= '0;
      r_trig_addr   <= '0;
      r_data_ready  <= 1'b0;
      r_event_count <= '0;
      r_event_time  <= '0;
      r_post_cnt    <= '0;
      r_hold_cnt    <= '0;
    end else begin
      if (r_buf_we) begin
        r_buf_addr <= r_buf_addr + ADDR_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (arm_en) begin
            r_state  <= S_ARMED;
            r_buf_we <= 1'b1;
          end
        end
        S_ARMED: begin
          // A trigger edge takes priority over arm_en dropping
          if (w_trig_rise) begin
            r_trig_addr   <= r_buf_addr;
            r_event_time  <= r_timestamp;
            r_event_count <= r_event_count + CNT_W'(1);
            if (post_samples == 16'd0) begin
              r_state      <= S_READY;
              r_buf_we     <= 1'b0;
              r_data_ready <= 1'b1;
            end else begin
              r_post_cnt <= post_samples;
              r_state    <= S_POST;
            end
          end else if (!arm_en) begin
            r_state  <= S_IDLE;
            r_buf_we <= 1'b0;
          end
        end
        S_POST: begin
          if (r_post_cnt == 16'd1) begin
            r_state      <= S_READY;
            r_buf_we     <= 1'b0;
            r_data_ready <= 1'b1;
          end else begin
            r_post_cnt <= r_post_cnt - 16'd1;
          end
        end
        S_READY: begin
          if (rd_ack) begin
            r_data_ready <= 1'b0;
            if (holdoff == 16'd0) begin
              if (arm_en) begin
                r_state  <= S_ARMED;
                r_buf_we <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_hold_cnt <= holdoff;
              r_state    <= S_HOLDOFF;
            end
          end
        end
        S_HOLDOFF: begin
          if (r_hold_cnt == 16'd1) begin
            if (arm_en) begin
              r_state  <= S_ARMED;
              r_buf_we <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_buf_we     <= 1'b0;
          r_data_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISSED_TRIG_EN
  logic [CNT_W-1:0] r_missed_count;
  logic             r_arm_d;

  assign missed_count = r_missed_count;

  // Count trigger edges lost while busy; a fresh arm from IDLE clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_missed_count <= '0;
      r_arm_d        <= 1'b0;
    end else begin
      r_arm_d <= arm_en;
      if (r_state == S_IDLE && arm_en && !r_arm_d) begin
        r_missed_count <= '0;
      end else if (w_trig_rise && (r_state == S_POST || r_state == S_READY ||
                                   r_state == S_HOLDOFF)) begin
        r_missed_count <= r_missed_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
